meter_countdown: RTL
====================

Name: meter_countdown

Overview:
- Downstream consumer of the 1 Hz divided clock (period 1 s, 50% duty, toggles every 25,000,000 fastclk cycles).
- Runs on fastclk and treats slowclk as a data input: synchronizes it and derives a one-cycle 1-second tick from it.
- Holds the parking meter's remaining time in seconds, applies coin-add and preset buttons, and counts down.
- Drives the binary and BCD time for the display stage, plus the expired/low-time status and the display blink enable.

Parameters:
- MAX_TIME, 9999: saturation ceiling for the remaining time, in seconds.
- LOW_THRESH, 200: the time is "low" when 0 < time < LOW_THRESH.
- ADD_A, 60: seconds added by add_a.
- ADD_B, 120: seconds added by add_b.
- ADD_C, 180: seconds added by add_c.
- ADD_D, 300: seconds added by add_d.
- PRESET_LO, 15: load value for preset_lo.
- PRESET_HI, 150: load value for preset_hi.

Ports:
- fastclk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- slowclk  in  1  1 Hz clock from the divider; sampled as data, never used as a clock.
- add_a  in  1  coin button, level; adds ADD_A on its rising edge.
- add_b  in  1  coin button, level; adds ADD_B on its rising edge.
- add_c  in  1  coin button, level; adds ADD_C on its rising edge.
- add_d  in  1  coin button, level; adds ADD_D on its rising edge.
- preset_lo  in  1  loads PRESET_LO on its rising edge.
- preset_hi  in  1  loads PRESET_HI on its rising edge.
- time_bin  out  14  remaining seconds, binary.
- time_bcd  out  16  remaining seconds as 4 BCD digits, thousands digit in [15:12].
- expired  out  1  high when time_bin == 0.
- low_time  out  1  high when 0 < time_bin < LOW_THRESH.
- blink  out  1  display enable.

Behaviour:
- Reset (reset_n low, asynchronous): all synchronizer and edge flops 0, time_bin 0, time_bcd 16'h0000, expired 1, low_time 0, blink 0.
- Reset released mid-countdown: the meter restarts at 0 (expired).
- slowclk path: 2-flop synchronizer, then an edge flop. sec_tick is a single fastclk pulse on each synchronized 0→1 transition.
- Each button input: 2-flop synchronizer plus edge detect. A held button produces exactly one event.
- Update order, evaluated each fastclk cycle, with the result registered into time_bin:
  1. Any preset event: time = PRESET_HI if preset_hi fires, else PRESET_LO. preset_hi wins when both fire in the same cycle. Adds and tick are ignored that cycle.
  2. Otherwise: time = min(MAX_TIME, time + sum of all add events this cycle − dec). dec = 1 if sec_tick and time > 0, else 0.
- Arithmetic width: sums use a 16-bit intermediate; saturation applies after the decrement.
- Decrement when time == 0: no-op, never wraps.
- Add arriving in the same cycle as a tick at time 0: dec = 0, so 0 + 60 gives 60.
- time_bcd: binary-to-BCD conversion of time_bin, registered. It lags time_bin by exactly 1 fastclk cycle.
- expired and low_time: registered from the next-state time, so they change in the same cycle as time_bin.
- blink, registered:
  - time ≥ LOW_THRESH: 1.
  - Low time: toggles on every sec_tick, giving 1 s on / 1 s off. Forced to 1 on entry to the low range.
  - Expired: follows the synchronized slowclk level, giving 0.5 s on / 0.5 s off.
- Transition from expired to nonzero: blink follows the rules above from the next cycle.
- Preset or add events occurring between ticks do not reset the 1 s phase.

Test Plan:
- Reset, then 3 sec_ticks with no buttons → time_bin stays 0, expired 1, time_bcd 16'h0000, blink tracks synced slowclk.
- Press add_b, then 5 slowclk rising edges → time_bin 120→115; time_bcd 16'h0115 one cycle after time_bin; low_time 1; blink toggles on each tick.
- preset_hi held 10 cycles, then add_d pulsed together with a sec_tick edge → time_bin 150, then 449; low_time 0, blink 1.
- From 9990, press add_d → time_bin saturates at 9999, time_bcd 16'h9999; the next tick gives 9998.
- preset_lo and preset_hi in the same cycle while add_a fires → time_bin 150 exactly.
- Load 15, let it count to 0, then assert reset_n low asynchronously mid-cycle → outputs hit their reset values immediately; no tick is counted during reset.

Source files
------------

// File: rtl/meter_countdown.sv
// Parking-meter countdown: synchronizes the 1 Hz slowclk and the buttons into fastclk,
// keeps the remaining seconds, and drives binary/BCD time plus expired, low-time and blink status.
module meter_countdown #(
   parameter int unsigned MAX_TIME   = 9999,
   parameter int unsigned LOW_THRESH = 200,
   parameter int unsigned ADD_A      = 60,
   parameter int unsigned ADD_B      = 120,
   parameter int unsigned ADD_C      = 180,
   parameter int unsigned ADD_D      = 300,
   parameter int unsigned PRESET_LO  = 15,
   parameter int unsigned PRESET_HI  = 150
) (
   input  logic        fastclk,
   input  logic        reset_n,
   input  logic        slowclk,
   input  logic        add_a,
   input  logic        add_b,
   input  logic        add_c,
   input  logic        add_d,
   input  logic        preset_lo,
   input  logic        preset_hi,
   output logic [13:0] time_bin,
   output logic [15:0] time_bcd,
   output logic        expired,
   output logic        low_time,
   output logic        blink
);

   localparam logic [15:0] MAX16 = 16'(MAX_TIME);
   localparam logic [13:0] MAX14 = 14'(MAX_TIME);
   localparam logic [15:0] LOW16 = 16'(LOW_THRESH);
   localparam logic [15:0] A16   = 16'(ADD_A);
   localparam logic [15:0] B16   = 16'(ADD_B);
   localparam logic [15:0] C16   = 16'(ADD_C);
   localparam logic [15:0] D16   = 16'(ADD_D);
   localparam logic [13:0] PL14  = 14'(PRESET_LO);
   localparam logic [13:0] PH14  = 14'(PRESET_HI);

   logic        slow_s1_q, slow_s2_q, slow_e_q;
   logic        sec_tick;
   logic [5:0]  btn_raw;
   logic [5:0]  btn_s1_q, btn_s2_q, btn_e_q;
   logic [5:0]  btn_evt;
   logic [13:0] time_q, time_d;
   logic [15:0] time_bcd_q;
   logic        expired_q, expired_d;
   logic        low_q, low_d;
   logic        blink_q, blink_d;
   logic [15:0] add_sum;
   logic [15:0] dec;
   logic [15:0] sum16;

   // Bit order: {preset_hi, preset_lo, add_d, add_c, add_b, add_a}
   assign btn_raw  = {preset_hi, preset_lo, add_d, add_c, add_b, add_a};
   assign btn_evt  = btn_s2_q & ~btn_e_q;
   assign sec_tick = slow_s2_q & ~slow_e_q;

   function automatic logic [15:0] to_bcd(input logic [13:0] bin);
      logic [29:0] sh;
      sh = {16'd0, bin};
      for (int i = 0; i < 14; i++) begin
         for (int d = 0; d < 4; d++) begin
            if (sh[14+4*d +: 4] >= 4'd5)
               sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
         end
         sh = sh << 1;
      end
      return sh[29:14];
   endfunction

   always_ff @(posedge fastclk or negedge reset_n) begin
      if (!reset_n) begin
         slow_s1_q <= 1'b0;
         slow_s2_q <= 1'b0;
         slow_e_q  <= 1'b0;
         btn_s1_q  <= '0;
         btn_s2_q  <= '0;
         btn_e_q   <= '0;
      end else begin
         slow_s1_q <= slowclk;
         slow_s2_q <= slow_s1_q;
         slow_e_q  <= slow_s2_q;
         btn_s1_q  <= btn_raw;
         btn_s2_q  <= btn_s1_q;
         btn_e_q   <= btn_s2_q;
      end
   end

   // Presets override everything; otherwise adds and the tick combine, then saturate.
   always_comb begin
      add_sum = 16'd0;
      if (btn_evt[0]) add_sum = add_sum + A16;
      if (btn_evt[1]) add_sum = add_sum + B16;
      if (btn_evt[2]) add_sum = add_sum + C16;
      if (btn_evt[3]) add_sum = add_sum + D16;
      dec   = (sec_tick && (time_q != 14'd0)) ? 16'd1 : 16'd0;
      sum16 = {2'b00, time_q} + add_sum - dec;
      if (btn_evt[5])
         time_d = PH14;
      else if (btn_evt[4])
         time_d = PL14;
      else if (sum16 > MAX16)
         time_d = MAX14;
      else
         time_d = sum16[13:0];
   end

   always_comb begin
      expired_d = (time_d == 14'd0);
      low_d     = !expired_d && ({2'b00, time_d} < LOW16);
      if (expired_d)
         blink_d = slow_s2_q;
      else if (!low_d)
         blink_d = 1'b1;
      else if (!low_q)
         blink_d = 1'b1;
      else if (sec_tick)
         blink_d = ~blink_q;
      else
         blink_d = blink_q;
   end

   always_ff @(posedge fastclk or negedge reset_n) begin
      if (!reset_n) begin
         time_q     <= 14'd0;
         time_bcd_q <= 16'h0000;
         expired_q  <= 1'b1;
         low_q      <= 1'b0;
         blink_q    <= 1'b0;
      end else begin
         time_q     <= time_d;
         time_bcd_q <= to_bcd(time_q);
         expired_q  <= expired_d;
         low_q      <= low_d;
         blink_q    <= blink_d;
      end
   end

   assign time_bin = time_q;
   assign time_bcd = time_bcd_q;
   assign expired  = expired_q;
   assign low_time = low_q;
   assign blink    = blink_q;

endmodule
